// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: single-port SRAM macro front end.
//   Accepts read/write requests on a valid/ready handshake and converts each
//   accepted request into one macro access in the same cycle. Read data comes
//   back from the macro one cycle after issue and is captured in a 2-entry
//   response FIFO. The FIFO is drained by a valid/ready consumer.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_*               request channel (valid/ready, we, addr, wdata)
//   rsp_*               read response channel (valid/ready, rdata)
//   sram_cen/wen/a/d/q  macro access pins (active-low enables)
//   sram_ema..colldisn  static macro controls
//   busy                read in flight or response buffered
module sram_port_ctrl #(
  parameter int          AW       = 8,
  parameter int          DW       = 64,
  parameter logic [2:0]  EMA_VAL  = 3'b010,
  parameter logic [1:0]  EMAW_VAL = 2'b00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic [2:0]    sram_ema,
  output logic [1:0]    sram_emaw,
  output logic          sram_ten,
  output logic          sram_ret1n,
  output logic          sram_se,
  output logic          sram_dftrambyp,
  output logic          sram_colldisn,
  output logic          busy
);

  logic               run;         // low in reset, high from the first edge after release
  logic               rd_pend;     // macro read issued last edge, sram_q valid this cycle
  logic [1:0][DW-1:0] fifo_mem;
  logic               wptr, rptr;
  logic [1:0]         fifo_count;
  logic               accept, push, pop;
  logic [2:0]         rd_occ;

  assign pop    = rsp_valid & rsp_ready;
  assign push   = rd_pend;

  // Slots a new read would need: the read already in the macro plus buffered
  // entries, minus the one leaving this cycle. pop <= fifo_count, so no underflow.
  assign rd_occ = {2'b00, rd_pend} + {1'b0, fifo_count} - {2'b00, pop};

  // Reset gating goes through a flop so rst_n is never used as data.
  assign req_ready = run & (req_we | (rd_occ < 3'd2));
  assign accept    = req_valid & req_ready;

  assign sram_cen  = ~accept;
  assign sram_wen  = ~(accept & req_we);
  assign sram_a    = req_addr;
  assign sram_d    = req_wdata;

  assign sram_ema       = EMA_VAL;
  assign sram_emaw      = EMAW_VAL;
  assign sram_ten       = 1'b1;
  assign sram_ret1n     = 1'b1;
  assign sram_se        = 1'b0;
  assign sram_dftrambyp = 1'b0;
  assign sram_colldisn  = 1'b1;

  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_rdata = fifo_mem[rptr];
  assign busy      = rd_pend | (fifo_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      rd_pend    <= 1'b0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      run        <= 1'b1;
      rd_pend    <= accept & ~req_we;
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload needs no reset; occupancy is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= sram_q;
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: scoreboard bench for sram_port_ctrl with a behavioural
// macro model. Expected read data is taken from a reference memory at the
// moment a read is accepted and queued; the monitor pops on each response.
module tb_sram_port_ctrl;
  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, sram_q;
  logic [2:0]    sram_ema;
  logic [1:0]    sram_emaw;
  logic          sram_ten, sram_ret1n, sram_se, sram_dftrambyp, sram_colldisn;
  logic          busy;

  sram_port_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q),
    .sram_ema(sram_ema), .sram_emaw(sram_emaw), .sram_ten(sram_ten),
    .sram_ret1n(sram_ret1n), .sram_se(sram_se),
    .sram_dftrambyp(sram_dftrambyp), .sram_colldisn(sram_colldisn),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Macro model: sync read/write, q holds across writes and idle cycles.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q      <= mem[sram_a];
    end
  end

  int            vectors = 0, miscompares = 0, cyc = 0;
  int            last_wait, last_acc;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] pop_dat[$];
  int            pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected got=%h expected no response", rsp_rdata);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (rsp_rdata !== exp) begin
          miscompares++;
          $display("FAIL rsp_data got=%h expected=%h", rsp_rdata, exp);
        end
      end
      pop_dat.push_back(rsp_rdata);
      pop_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_timeout addr=%h req_ready=%b expected 1", a, req_ready);
    end else begin
      last_acc = cyc;
      if (sram_cen !== 1'b0 || sram_wen !== ~we || sram_a !== a || (we && sram_d !== d)) begin
        miscompares++;
        $display("FAIL issue_pins cen=%b wen=%b a=%h d=%h expected cen=0 wen=%b a=%h d=%h",
                 sram_cen, sram_wen, sram_a, sram_d, ~we, a, d);
      end
      if (we) ref_mem[a] = d;
      else    sb.push_back(ref_mem[a]);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0 || sram_cen !== 1'b1 || sram_wen !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state ready=%b cen=%b wen=%b rsp_valid=%b busy=%b expected 0 1 1 0 0",
               req_ready, sram_cen, sram_wen, rsp_valid, busy);
    end
    vectors++;
    if (sram_ema !== 3'b010 || sram_emaw !== 2'b00 || sram_ten !== 1'b1 || sram_ret1n !== 1'b1 ||
        sram_se !== 1'b0 || sram_dftrambyp !== 1'b0 || sram_colldisn !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ties ema=%b emaw=%b ten=%b ret1n=%b se=%b byp=%b colldisn=%b expected 010 00 1 1 0 0 1",
               sram_ema, sram_emaw, sram_ten, sram_ret1n, sram_se, sram_dftrambyp, sram_colldisn);
    end
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    @(negedge clk);
    vectors++;
    if (sram_cen !== 1'b1 || sram_wen !== 1'b1 || sram_ema !== 3'b010 || sram_ten !== 1'b1 || sram_ret1n !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_pins cen=%b wen=%b ema=%b ten=%b ret1n=%b expected 1 1 010 1 1",
               sram_cen, sram_wen, sram_ema, sram_ten, sram_ret1n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int acc;
    rsp_ready = 1'b1;
    issue(1'b1, 8'h10, 64'hA5A5_0000_0000_0001);
    @(negedge clk);
    vectors++;
    if (sram_cen !== 1'b1 || sram_wen !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_write cen=%b wen=%b expected 1 1", sram_cen, sram_wen);
    end
    @(posedge clk); #1;
    pop_cyc.delete();
    issue(1'b0, 8'h10, '0);
    acc = last_acc;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || sram_cen !== 1'b1) begin
      miscompares++;
      $display("FAIL read_t1 rsp_valid=%b busy=%b cen=%b expected 0 1 1", rsp_valid, busy, sram_cen);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hA5A5_0000_0000_0001) begin
      miscompares++;
      $display("FAIL read_t2 rsp_valid=%b rdata=%h expected 1 a5a5000000000001", rsp_valid, rsp_rdata);
    end
    step(3);
    vectors++;
    if (pop_cyc.size() != 1 || pop_cyc[0] != acc + 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read_latency pops=%0d busy=%b expected 1 pop at cycle %0d, busy 0",
               pop_cyc.size(), busy, acc + 2);
    end
  endtask

  task automatic test_back_to_back();
    int first, stalls;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), {32'hB2B0_0000, 32'(i * 7 + 3)});
    step(2);
    pop_cyc.delete();
    stalls = 0; first = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, AW'(i), '0);
      if (i == 0) first = last_acc;
      stalls += last_wait;
    end
    step(4);
    vectors++;
    if (stalls != 0) begin
      miscompares++;
      $display("FAIL b2b_ready stall_cycles=%0d expected 0", stalls);
    end
    vectors++;
    if (pop_cyc.size() != 8) begin
      miscompares++;
      $display("FAIL b2b_count responses=%0d expected 8", pop_cyc.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (pop_cyc[k] != first + 2 + k) begin
          miscompares++;
          $display("FAIL b2b_timing rsp %0d cycle=%0d expected %0d", k, pop_cyc[k], first + 2 + k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    pop_cyc.delete();
    issue(1'b0, 8'h00, '0);
    issue(1'b0, 8'h01, '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[0] || dut.fifo_count > 2'd2) begin
        miscompares++;
        $display("FAIL bp_stall cyc=%0d ready=%b rsp_valid=%b head=%h count=%0d expected 0 1 %h <=2",
                 i, req_ready, rsp_valid, rsp_rdata, dut.fifo_count, ref_mem[0]);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    issue(1'b0, 8'h02, '0);
    vectors++;
    if (last_wait != 0) begin
      miscompares++;
      $display("FAIL bp_release wait=%0d expected 0", last_wait);
    end
    step(5);
    vectors++;
    if (sb.size() != 0 || pop_cyc.size() != 3 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain pending=%0d responses=%0d busy=%b expected 0 3 0", sb.size(), pop_cyc.size(), busy);
    end
  endtask

  task automatic test_raw();
    rsp_ready = 1'b1;
    issue(1'b1, 8'h20, 64'h1);
    step(1);
    pop_dat.delete();
    issue(1'b0, 8'h20, '0);
    issue(1'b1, 8'h20, 64'h2);
    issue(1'b0, 8'h20, '0);
    step(5);
    vectors++;
    if (pop_dat.size() != 2) begin
      miscompares++;
      $display("FAIL raw_count responses=%0d expected 2", pop_dat.size());
    end else begin
      vectors++;
      if (pop_dat[0] !== 64'h1 || pop_dat[1] !== 64'h2) begin
        miscompares++;
        $display("FAIL raw_data got=%h,%h expected 1,2", pop_dat[0], pop_dat[1]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    issue(1'b0, 8'h03, '0);
    issue(1'b0, 8'h04, '0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1 || dut.rd_pend !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre busy=%b rsp_valid=%b rd_pend=%b expected 1 1 1", busy, rsp_valid, dut.rd_pend);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || sram_cen !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset rsp_valid=%b busy=%b ready=%b cen=%b expected 0 0 0 1",
               rsp_valid, busy, req_ready, sram_cen);
    end
    sb.delete();
    pop_cyc.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_after cyc=%0d rsp_valid=%b busy=%b expected 0 0", i, rsp_valid, busy);
      end
    end
    vectors++;
    if (pop_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL mid_stale responses=%0d expected 0", pop_cyc.size());
    end
    @(posedge clk); #1;
    // Block works again after the mid-flight reset.
    issue(1'b0, 8'h05, '0);
    step(4);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_raw();
    test_reset_midflight();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain pending=%0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
